// File: rtl/mp_mem_manager.sv
// Multi-port block allocator: round-robin grants from a fresh counter then a recycle FIFO.
// Optional MP_MEM_MGR_RLS_CHK_EN adds an in-use bitmap and the rls_err double-release pulse.
module mp_mem_manager #(
  parameter int AWIDTH       = 10,
  parameter int NUM_PORTS    = 4,
  parameter int AFULL_THRESH = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_PORTS-1:0]          ocp_req,
  output logic [NUM_PORTS-1:0]          ocp_gnt,
  output logic [AWIDTH-1:0]             ocp_block_addr,
  output logic                          ocp_vld,
  input  logic [NUM_PORTS-1:0]          rls_vld,
  input  logic [NUM_PORTS*AWIDTH-1:0]   rls_block_addr,
  output logic [NUM_PORTS-1:0]          rls_rdy,
  output logic [AWIDTH:0]               emp_block_num,
  output logic                          full,
  output logic                          almost_full,
  output logic                          empty
`ifdef MP_MEM_MGR_RLS_CHK_EN
  ,
  output logic                          rls_err
`endif
);

  localparam int              DEPTH    = 1 << AWIDTH;
  localparam int              PW       = $clog2(NUM_PORTS);
  localparam logic [PW:0]     NP_C     = (PW+1)'(NUM_PORTS);
  localparam logic [PW-1:0]   LAST_C   = PW'(NUM_PORTS-1);
  localparam logic [PW-1:0]   PORT_ONE = PW'(1);
  localparam logic [AWIDTH:0] CNT_ONE  = (AWIDTH+1)'(1);
  localparam logic [AWIDTH:0] THRESH_C = (AWIDTH+1)'(AFULL_THRESH);
  localparam logic [AWIDTH:0] DEPTH_C  = (AWIDTH+1)'(DEPTH);
  localparam logic [AWIDTH-1:0] PTR_ONE = AWIDTH'(1);

  // Returns {hit, winner}: first set bit of req scanning upward from ptr, wrapping.
  function automatic logic [PW:0] rr_pick(input logic [NUM_PORTS-1:0] req,
                                          input logic [PW-1:0]        ptr);
    logic [PW:0] res;
    logic [PW:0] pos;
    res = '0;
    for (int i = NUM_PORTS-1; i >= 0; i--) begin
      pos = {1'b0, ptr} + (PW+1)'(i);
      if (pos >= NP_C) pos = pos - NP_C;
      if (req[pos[PW-1:0]]) res = {1'b1, pos[PW-1:0]};
    end
    return res;
  endfunction

  function automatic logic [PW-1:0] rr_next(input logic [PW-1:0] win);
    return (win == LAST_C) ? '0 : win + PORT_ONE;
  endfunction

  logic [AWIDTH:0]        fresh_cnt;
  logic [AWIDTH-1:0]      wr_ptr;
  logic [AWIDTH-1:0]      rd_ptr;
  logic [AWIDTH-1:0]      fifo_mem [DEPTH];
  logic [PW-1:0]          alloc_ptr;
  logic [PW-1:0]          rls_ptr;
  logic [NUM_PORTS-1:0]   alloc_elig;
  logic [PW:0]            alloc_pick;
  logic [PW:0]            rls_pick;
  logic                   alloc_go;
  logic                   rls_go;
  logic                   rls_push;
  logic [PW-1:0]          alloc_win;
  logic [PW-1:0]          rls_win;
  logic                   fresh_avail;
  logic [AWIDTH-1:0]      src_addr;
  logic [AWIDTH-1:0]      rls_addr;

  // Stage 0: arbitration and source select, all combinational off registered state
  assign alloc_elig  = ocp_req & ~ocp_gnt;
  assign alloc_pick  = rr_pick(alloc_elig, alloc_ptr);
  assign alloc_go    = alloc_pick[PW] && !full;
  assign alloc_win   = alloc_pick[PW-1:0];
  assign rls_pick    = rr_pick(rls_vld, rls_ptr);
  assign rls_go      = rls_pick[PW];
  assign rls_win     = rls_pick[PW-1:0];
  assign fresh_avail = !fresh_cnt[AWIDTH];
  assign src_addr    = fresh_avail ? fresh_cnt[AWIDTH-1:0] : fifo_mem[rd_ptr];

  always_comb begin
    rls_rdy  = '0;
    rls_addr = '0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      if (rls_go && rls_win == PW'(i)) begin
        rls_rdy[i] = 1'b1;
        rls_addr   = rls_block_addr[i*AWIDTH +: AWIDTH];
      end
    end
  end

`ifdef MP_MEM_MGR_RLS_CHK_EN
  logic [DEPTH-1:0] in_use;

  // A release of a block that is not outstanding is acknowledged but dropped.
  assign rls_push = rls_go && in_use[rls_addr];

  always_ff @(posedge clk) begin
    if (rst) begin
      in_use  <= '0;
      rls_err <= 1'b0;
    end else begin
      if (alloc_go) in_use[src_addr] <= 1'b1;
      if (rls_push) in_use[rls_addr] <= 1'b0;
      rls_err <= rls_go && !in_use[rls_addr];
    end
  end
`else
  assign rls_push = rls_go;
`endif

  // Stage 1: grant, pointer and free-count registers
  always_ff @(posedge clk) begin
    if (rst) begin
      ocp_gnt        <= '0;
      ocp_vld        <= 1'b0;
      ocp_block_addr <= '0;
      emp_block_num  <= DEPTH_C;
      fresh_cnt      <= '0;
      wr_ptr         <= '0;
      rd_ptr         <= '0;
      alloc_ptr      <= '0;
      rls_ptr        <= '0;
    end else begin
      ocp_gnt <= '0;
      ocp_vld <= alloc_go;
      if (alloc_go) begin
        ocp_gnt[alloc_win] <= 1'b1;
        ocp_block_addr     <= src_addr;
        alloc_ptr          <= rr_next(alloc_win);
        if (fresh_avail) fresh_cnt <= fresh_cnt + CNT_ONE;
        else             rd_ptr    <= rd_ptr + PTR_ONE;
      end
      if (rls_go)   rls_ptr <= rr_next(rls_win);
      if (rls_push) wr_ptr  <= wr_ptr + PTR_ONE;
      if (rls_push && !alloc_go)      emp_block_num <= emp_block_num + CNT_ONE;
      else if (!rls_push && alloc_go) emp_block_num <= emp_block_num - CNT_ONE;
    end
  end

  always_ff @(posedge clk) begin
    if (rls_push) fifo_mem[wr_ptr] <= rls_addr;
  end

  assign full        = (emp_block_num == '0);
  assign almost_full = (emp_block_num <= THRESH_C);
  assign empty       = (emp_block_num == DEPTH_C);

endmodule
